// File: rtl/alu_operand_loader_if.sv
// Bus between the operand loader and its environment: the board switches and
// buttons, the combinational ALU, and the display outputs.
interface alu_operand_loader_if #(
  parameter int N = 4
);
  logic [N-1:0]   sw_data;
  logic [3:0]     sw_op;
  logic           btn_next;
  logic           btn_clear;
  logic [2*N-1:0] alu_resultado;
  logic [3:0]     alu_banderas;
  logic [N-1:0]   operand1;
  logic [N-1:0]   operand2;
  logic [3:0]     op_select;
  logic [2*N-1:0] result_reg;
  logic [3:0]     flags_reg;
  logic           result_valid;
  logic [2:0]     state_code;

  // Environment side: switches, buttons and ALU drive; display outputs observed.
  modport master (
    output sw_data, sw_op, btn_next, btn_clear, alu_resultado, alu_banderas,
    input  operand1, operand2, op_select, result_reg, flags_reg, result_valid, state_code
  );

  // Loader side.
  modport slave (
    input  sw_data, sw_op, btn_next, btn_clear, alu_resultado, alu_banderas,
    output operand1, operand2, op_select, result_reg, flags_reg, result_valid, state_code
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand loader in front of the combinational ALU. Operand1, operand2 and the
// op code are stepped in from the switches with a debounced "next" button. The
// ALU result and flags are then captured and held for display.
module alu_operand_loader #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 500000
) (
  input logic                 clk,
  input logic                 rst,
  alu_operand_loader_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic [1:0]     sync_next_q, sync_next_d;
  logic [1:0]     sync_clear_q, sync_clear_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           db_level_q, db_level_d;
  logic           next_pulse_q, next_pulse_d;
  logic           s_next, s_clear;

  state_t         state_q, state_d;
  logic [N-1:0]   operand1_q, operand1_d;
  logic [N-1:0]   operand2_q, operand2_d;
  logic [3:0]     op_select_q, op_select_d;
  logic [2*N-1:0] result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           result_valid_q, result_valid_d;

  assign s_next  = sync_next_q[1];
  assign s_clear = sync_clear_q[1];

  // Synchronize both buttons, then debounce "next" into a single-cycle press pulse.
  always_comb begin
    sync_next_d  = {sync_next_q[0], bus.btn_next};
    sync_clear_d = {sync_clear_q[0], bus.btn_clear};
    cnt_d        = cnt_q;
    db_level_d   = db_level_q;
    next_pulse_d = 1'b0;
    if (s_next == db_level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_level_d   = s_next;
      cnt_d        = '0;
      next_pulse_d = s_next;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Register the synchronizer and debounce state; clear does not touch these.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_next_q  <= '0;
      sync_clear_q <= '0;
      cnt_q        <= '0;
      db_level_q   <= 1'b0;
      next_pulse_q <= 1'b0;
    end else begin
      sync_next_q  <= sync_next_d;
      sync_clear_q <= sync_clear_d;
      cnt_q        <= cnt_d;
      db_level_q   <= db_level_d;
      next_pulse_q <= next_pulse_d;
    end
  end

  // Entry sequence: step through the operands and op code, give the ALU one
  // cycle to settle, then capture and hold its result. Clear beats any press.
  always_comb begin
    state_d        = state_q;
    operand1_d     = operand1_q;
    operand2_d     = operand2_q;
    op_select_d    = op_select_q;
    result_d       = result_q;
    flags_d        = flags_q;
    result_valid_d = result_valid_q;
    if (s_clear) begin
      state_d        = S_A;
      operand1_d     = '0;
      operand2_d     = '0;
      op_select_d    = '0;
      result_d       = '0;
      flags_d        = '0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: if (next_pulse_q) begin
          operand1_d = bus.sw_data;
          state_d    = S_B;
        end
        S_B: if (next_pulse_q) begin
          operand2_d = bus.sw_data;
          state_d    = S_OP;
        end
        S_OP: if (next_pulse_q) begin
          op_select_d = bus.sw_op;
          state_d     = S_EXEC;
        end
        S_EXEC: begin
          result_d       = bus.alu_resultado;
          flags_d        = bus.alu_banderas;
          result_valid_d = 1'b1;
          state_d        = S_SHOW;
        end
        S_SHOW: if (next_pulse_q) begin
          result_valid_d = 1'b0;
          state_d        = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  // Register the state and every displayed or ALU-facing value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_A;
      operand1_q     <= '0;
      operand2_q     <= '0;
      op_select_q    <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      operand1_q     <= operand1_d;
      operand2_q     <= operand2_d;
      op_select_q    <= op_select_d;
      result_q       <= result_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.operand1     = operand1_q;
  assign bus.operand2     = operand2_q;
  assign bus.op_select    = op_select_q;
  assign bus.result_reg   = result_q;
  assign bus.flags_reg    = flags_q;
  assign bus.result_valid = result_valid_q;
  assign bus.state_code   = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for the ALU operand loader. It uses a behavioural ALU, a stage-based
// entry model and a result scoreboard drained by an independent monitor.
module tb_alu_operand_loader;
  localparam int N  = 4;
  localparam int DB = 4;

  typedef struct {
    logic [2*N-1:0] res;
    logic [3:0]     flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic valid_prev = 1'b0;

  alu_operand_loader_if #(.N(N)) bus ();

  alu_operand_loader #(.N(N), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [3:0] op);
    logic [2*N-1:0] ea, eb;
    ea = {{N{1'b0}}, a};
    eb = {{N{1'b0}}, b};
    case (op)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return ea & eb;
      4'd4:    return ea | eb;
      4'd5:    return ea ^ eb;
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [3:0] flag_model(input logic [2*N-1:0] r);
    return {(r == '0), r[N], r[2*N-1], ^r};
  endfunction

  // Behavioural ALU driven by the loader's registered operands.
  always_comb begin
    bus.alu_resultado = alu_model(bus.operand1, bus.operand2, bus.op_select);
    bus.alu_banderas  = flag_model(bus.alu_resultado);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Monitor: each fresh result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.result_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", 32'(bus.result_reg), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("sb_result", 32'(bus.result_reg), 32'(e.res));
        check_output("sb_flags", 32'(bus.flags_reg), 32'(e.flg));
      end
    end
    valid_prev = bus.result_valid;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean press: high for 4 sampled edges, then the release is debounced.
  task automatic apply_stimulus(input logic [N-1:0] data, input logic [3:0] op);
    bus.sw_data = data;
    bus.sw_op   = op;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(4);
    bus.btn_next = 1'b0;
    wait_neg(9);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.btn_clear = 1'b1;
    wait_neg(1);
    bus.btn_clear = 1'b0;
    wait_neg(4);
  endtask

  // Full entry of one operation, scoreboarded, followed by the return press.
  task automatic enter_operation(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op);
    exp_t e;
    int   guard;
    apply_stimulus(a, 4'hF);
    check_output("stage_b", 32'(bus.state_code), 32'd1);
    check_output("operand1", 32'(bus.operand1), 32'(a));
    apply_stimulus(b, 4'hF);
    check_output("stage_op", 32'(bus.state_code), 32'd2);
    check_output("operand2", 32'(bus.operand2), 32'(b));
    e.res = alu_model(a, b, op);
    e.flg = flag_model(e.res);
    exp_q.push_back(e);
    bus.sw_op = op;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(4);
    bus.btn_next = 1'b0;
    wait_neg(3);
    check_output("exec_state", 32'(bus.state_code), 32'd3);
    wait_neg(1);
    check_output("show_state", 32'(bus.state_code), 32'd4);
    check_output("show_valid", 32'(bus.result_valid), 32'd1);
    check_output("op_select", 32'(bus.op_select), 32'(op));
    wait_neg(6);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    apply_stimulus(4'(~a), 4'hF);
    check_output("back_to_a", 32'(bus.state_code), 32'd0);
    check_output("valid_dropped", 32'(bus.result_valid), 32'd0);
    check_output("operand1_kept", 32'(bus.operand1), 32'(a));
    check_output("result_kept", 32'(bus.result_reg), 32'(e.res));
  endtask

  initial begin
    bus.sw_data   = 4'hA;
    bus.sw_op     = 4'h6;
    bus.btn_next  = 1'b0;
    bus.btn_clear = 1'b0;

    // Reset with nonzero switches.
    rst = 1'b1;
    wait_neg(3);
    check_output("rst_operand1", 32'(bus.operand1), 32'd0);
    check_output("rst_operand2", 32'(bus.operand2), 32'd0);
    check_output("rst_op", 32'(bus.op_select), 32'd0);
    check_output("rst_result", 32'(bus.result_reg), 32'd0);
    check_output("rst_flags", 32'(bus.flags_reg), 32'd0);
    check_output("rst_valid", 32'(bus.result_valid), 32'd0);
    check_output("rst_state", 32'(bus.state_code), 32'd0);
    rst = 1'b0;
    wait_neg(2);

    // Directed operations, including the known add and multiply values.
    enter_operation(4'd5, 4'd9, 4'b0000);
    check_output("add_5_9", 32'(bus.result_reg), 32'h0E);
    enter_operation(4'd7, 4'd3, 4'b0010);
    check_output("mul_7_3", 32'(bus.result_reg), 32'h15);
    enter_operation(4'd15, 4'd15, 4'b0010);
    check_output("mul_max", 32'(bus.result_reg), 32'hE1);

    // Randomized operations.
    for (int i = 0; i < 6; i++) begin
      enter_operation(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 7)));
    end

    // Short glitch and bounce must not advance.
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(3);
    bus.btn_next = 1'b0;
    wait_neg(2);
    for (int k = 0; k < 2; k++) begin
      bus.btn_next = 1'b1;
      wait_neg(2);
      bus.btn_next = 1'b0;
      wait_neg(2);
    end
    wait_neg(12);
    check_output("glitch_no_advance", 32'(bus.state_code), 32'd0);

    // Clean press: pulse five edges after first sampling, state moves one edge later.
    bus.sw_data = 4'd11;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(4);
    bus.btn_next = 1'b0;
    wait_neg(2);
    check_output("press_not_early", 32'(bus.state_code), 32'd0);
    wait_neg(1);
    check_output("press_on_time", 32'(bus.state_code), 32'd1);
    check_output("press_operand1", 32'(bus.operand1), 32'd11);
    wait_neg(10);
    pulse_clear();
    check_output("clear_state", 32'(bus.state_code), 32'd0);
    check_output("clear_operand1", 32'(bus.operand1), 32'd0);

    // Long hold advances once; a short release blip does not re-arm.
    bus.sw_data = 4'd6;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(100);
    check_output("hold_one_advance", 32'(bus.state_code), 32'd1);
    bus.btn_next = 1'b0;
    wait_neg(2);
    bus.btn_next = 1'b1;
    wait_neg(20);
    check_output("blip_no_advance", 32'(bus.state_code), 32'd1);
    bus.btn_next = 1'b0;
    wait_neg(10);
    apply_stimulus(4'd2, 4'hF);
    check_output("rearmed_advance", 32'(bus.state_code), 32'd2);
    pulse_clear();

    // Clear coinciding with the op press wins.
    apply_stimulus(4'd5, 4'hF);
    apply_stimulus(4'd9, 4'hF);
    check_output("pre_clear_state", 32'(bus.state_code), 32'd2);
    bus.sw_op = 4'd0;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(4);
    bus.btn_next  = 1'b0;
    bus.btn_clear = 1'b1;
    wait_neg(1);
    bus.btn_clear = 1'b0;
    wait_neg(2);
    check_output("race_state", 32'(bus.state_code), 32'd0);
    check_output("race_operand1", 32'(bus.operand1), 32'd0);
    check_output("race_operand2", 32'(bus.operand2), 32'd0);
    wait_neg(10);
    check_output("race_no_exec", 32'(bus.state_code), 32'd0);
    check_output("race_valid", 32'(bus.result_valid), 32'd0);

    // Reset during EXEC discards the result.
    apply_stimulus(4'd5, 4'hF);
    apply_stimulus(4'd9, 4'hF);
    bus.sw_op = 4'd0;
    @(negedge clk);
    bus.btn_next = 1'b1;
    wait_neg(4);
    bus.btn_next = 1'b0;
    wait_neg(3);
    check_output("pre_rst_exec", 32'(bus.state_code), 32'd3);
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    check_output("rst_exec_state", 32'(bus.state_code), 32'd0);
    check_output("rst_exec_result", 32'(bus.result_reg), 32'd0);
    check_output("rst_exec_valid", 32'(bus.result_valid), 32'd0);
    wait_neg(8);
    check_output("rst_exec_settled", 32'(bus.state_code), 32'd0);
    check_output("rst_exec_no_valid", 32'(bus.result_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front-end stage directly upstream of the team's combinational ALU.
- Lets the operator enter operand1, operand2 and the 4-bit op code one at a time from board switches, using a single debounced "next" button.
- Drives the ALU's operand/op inputs from registers, captures the ALU's result and 4-bit flags into output registers, and holds them for display.

Parameters:
N, 4, operand width; must match the ALU's N.
DB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (bench uses 4).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
sw_data  input  N  operand value from switches.
sw_op  input  4  operation code from switches.
btn_next  input  1  raw, asynchronous, bouncy push-button.
btn_clear  input  1  raw asynchronous clear request, level-sensitive.
alu_resultado  input  2N  result from the ALU.
alu_banderas  input  4  flags from the ALU.
operand1  output  N  registered operand to the ALU.
operand2  output  N  registered operand to the ALU.
op_select  output  4  registered op code to the ALU.
result_reg  output  2N  latched ALU result.
flags_reg  output  4  latched ALU flags.
result_valid  output  1  high while result_reg/flags_reg hold a fresh result.
state_code  output  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (rst=1 at a clk edge):
  - operand1, operand2, op_select, result_reg, flags_reg = 0.
  - result_valid = 0; state = S_A (state_code 3'd0).
  - Synchronizers, debounce counter and debounced level = 0.
  - rst overrides every other event, including mid-EXEC.
- Synchronization: btn_next and btn_clear each pass through a 2-FF synchronizer; s_next and s_clear are the second-stage outputs.
- Debounce (btn_next only):
  - cnt is cleared whenever s_next == db_level.
  - Otherwise cnt increments.
  - When s_next != db_level and cnt == DB_CYCLES-1: db_level <= s_next, cnt <= 0.
  - next_pulse is a register set to 1 on exactly that edge when the transition is 0->1, else 0.
  - A raw rise first sampled at edge e0 yields next_pulse high for exactly one cycle after edge e0+DB_CYCLES+1.
  - A bounce/glitch holding s_next for fewer than DB_CYCLES cycles produces no pulse.
  - Holding the button produces only one pulse; release must also be debounced before another press is accepted.
- FSM (state_code in brackets), transitions on clk:
  - S_A [0]: on next_pulse, operand1 <= sw_data, go to S_B.
  - S_B [1]: on next_pulse, operand2 <= sw_data, go to S_OP.
  - S_OP [2]: on next_pulse, op_select <= sw_op, go to S_EXEC.
  - S_EXEC [3]: exactly one cycle, lets the combinational ALU settle on the registered inputs. At its closing edge: result_reg <= alu_resultado, flags_reg <= alu_banderas, result_valid <= 1, go to S_SHOW.
  - S_SHOW [4]: hold all outputs. On next_pulse: result_valid <= 0, go to S_A. operand1, operand2 and op_select keep their old values until overwritten.
  - Unused encodings 5-7 go to S_A on the next edge.
- Clear:
  - s_clear == 1 at an edge has the same effect as rst on all FSM/data registers: state S_A, all outputs zeroed, result_valid 0.
  - Synchronizers and the debounce logic are unaffected.
  - Clear has priority over a simultaneous next_pulse.
  - Clear is held while s_clear stays high.
- next_pulse arriving in S_EXEC is ignored (it cannot occur in practice, but is defined).
- Widths:
  - result_reg is captured as the full 2N bits with no manipulation.
  - Operands are captured unsigned, with no extension.

Test Plan:
1. Assert rst 3 cycles with switches at nonzero values -> every output is 0, state_code=0, result_valid=0.
2. DB_CYCLES=4, N=4, ALU instance connected. Enter sw_data=5 (press), 9 (press), sw_op=4'b0000 (press) -> operand1=5, operand2=9, op_select=0; one cycle in state 3, then result_reg=8'h0E, result_valid=1, state_code=4. Entering op 4'b0010 with 7,3 instead -> result_reg=8'h15.
3. btn_next glitch high for 3 cycles, then bounce 1/0/1/0 at 2-cycle intervals -> no next_pulse, state unchanged. A clean press held 4+ cycles -> exactly one pulse, arriving 5 edges after first sampling.
4. btn_next held high for 100 cycles in S_A -> exactly one advance, to S_B; the next press only registers after release is debounced.
5. In S_OP with operand1=5, operand2=9, assert btn_clear on the same cycle a pulse would fire -> after synchronizer latency, state_code=0, operands/op=0, no advance to S_EXEC.
6. Assert rst on the S_EXEC cycle -> result_reg stays 0, result_valid=0, state_code=0; the ALU result is not captured.
